ra_verify: RTL and testbench
============================

Name: ra_verify

Overview:
- Resolution-side companion to the fetch-stage return address stack.
- Fetch pops the stack and speculatively redirects to a predicted return address. This block records each prediction in order.
- When execute resolves the actual target of each return jump, the block compares it with the recorded prediction. On mismatch it raises a one-cycle mispredict with the corrected PC and squashes all younger in-flight predictions.
- Also keeps hit/miss statistics and sticky error flags for debug readout.

Parameters:
- PC_W, 14, instruction address width (matches stack entry width).
- DEPTH, 8, max in-flight unresolved return predictions; power of two.
- CNT_W, 16, width of hit/miss statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  pipeline stall; freezes all state.
- flush_in  in  1  external squash (older mispredict/exception); empties queue.
- pred_valid  in  1  fetch issued a stack-predicted return this cycle.
- pred_ra  in  PC_W  predicted return address.
- res_valid  in  1  execute resolved the oldest in-flight return.
- res_target  in  PC_W  actual return target.
- full  out  1  queue holds DEPTH entries; fetch must not predict while high.
- count  out  $clog2(DEPTH)+1  entries in flight.
- mispredict  out  1  registered one-cycle pulse.
- redirect_pc  out  PC_W  corrected PC; valid when mispredict=1.
- hit_cnt  out  CNT_W  saturating count of correct predictions.
- miss_cnt  out  CNT_W  saturating count of mispredictions.
- err_ovf  out  1  sticky: pred_valid while full and no pop.
- err_unf  out  1  sticky: res_valid while empty.

Behaviour:
- Reset (rst_n=0, async): all outputs 0, rd/wr pointers 0, count 0. Queue RAM contents need not be cleared. Reset mid-operation discards every in-flight entry immediately.
- Queue: circular FIFO, DEPTH entries, in order. Pointers wrap modulo DEPTH. full = (count==DEPTH).
- All updates occur only on clk rising edge with stall=0. With stall=1, no state changes and mispredict is driven 0 that cycle. redirect_pc holds its value.
- Priority per unstalled cycle: flush_in > resolve > push.
- flush_in=1: count←0, pointers equal. pred_valid/res_valid ignored. Counters unchanged. mispredict←0.
- Resolve (res_valid=1, count>0): compare head entry with res_target.
  - Match: pop head, hit_cnt+1. If pred_valid is also 1, push in the same cycle and count is unchanged (allowed even when full).
  - Mismatch: queue emptied (count←0), same-cycle push dropped (younger), miss_cnt+1. Next cycle mispredict=1 and redirect_pc=res_target.
- Resolve on empty (count=0): err_unf←1. No mispredict, no counter change. A same-cycle push proceeds.
- Push only (pred_valid=1, no pop): if not full, write pred_ra at wr_ptr and count+1. If full, drop and set err_ovf←1.
- mispredict latency: exactly 1 cycle after the resolving edge; width exactly 1 cycle.
- Counters saturate at all-ones and never wrap. Sticky flags clear only on reset.

Test Plan:
- Reset: hold rst_n=0 mid-stream with count=3 -> count=0, full=0, all outputs 0 without waiting for a clock edge. Release, push 1 -> count=1.
- In-order hits: push 0x0100, 0x0200, 0x0300, then resolve each with matching targets -> mispredict never 1, hit_cnt=3, count=0.
- Mismatch squash: push 0x0100, 0x0200, 0x0300; resolve 0x0100 (match), then resolve 0x0AAA -> next cycle mispredict=1 for one cycle, redirect_pc=0x0AAA, count=0, miss_cnt=1, hit_cnt=1.
- Full and simultaneous: push 8 entries -> full=1. Push 9th alone -> dropped, err_ovf=1, count=8. Push + matching resolve together -> count stays 8, new entry becomes tail.
- Flush and stall: push 2, assert stall with res_valid mismatching -> no change, mispredict=0. Deassert stall, assert flush_in with res_valid mismatch -> count=0, mispredict=0, miss_cnt unchanged.
- Underflow and saturation: res_valid on empty -> err_unf=1, no mispredict. Force hit_cnt to 0xFFFF via 65535 hits, one more hit -> stays 0xFFFF.

Source files
------------

// File: rtl/ra_verify_if.sv
// Fetch/execute handshake bundle for the return-address verification queue.
interface ra_verify_if #(
    parameter int PC_W  = 14,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            pred_valid;
    logic [PC_W-1:0] pred_ra;
    logic            res_valid;
    logic [PC_W-1:0] res_target;
    logic            full;
    logic [CW-1:0]   count;
    logic            mispredict;
    logic [PC_W-1:0] redirect_pc;

    modport master (
        output pred_valid, pred_ra, res_valid, res_target,
        input  full, count, mispredict, redirect_pc
    );

    modport slave (
        input  pred_valid, pred_ra, res_valid, res_target,
        output full, count, mispredict, redirect_pc
    );
endinterface

// File: rtl/ra_verify.sv
// Records stack-predicted return addresses in order and checks them against
// resolved targets; a mismatch squashes the queue and redirects fetch.
module ra_verify #(
    parameter int PC_W  = 14,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush_in,
    ra_verify_if.slave       bus,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic             err_ovf,
    output logic             err_unf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PC_W-1:0]  mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             mispredict_q, mispredict_d;
    logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
    logic             err_ovf_q, err_ovf_d, err_unf_q, err_unf_d;
    logic             mem_we;
    logic             full, empty, head_hit;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign head_hit = (mem_q[rd_ptr_q] == bus.res_target);

    always_comb begin
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        mispredict_d  = mispredict_q;
        redirect_pc_d = redirect_pc_q;
        hit_cnt_d     = hit_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        err_ovf_d     = err_ovf_q;
        err_unf_d     = err_unf_q;
        mem_we        = 1'b0;
        if (!stall) begin
            mispredict_d = 1'b0;
            if (flush_in) begin
                count_d  = '0;
                rd_ptr_d = wr_ptr_q;
            end else if (bus.res_valid && !empty) begin
                if (head_hit) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
                    // Pop frees a slot, so a same-cycle push is legal even when full.
                    if (bus.pred_valid) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end else begin
                    // Everything younger, including a same-cycle push, is on the wrong path.
                    count_d       = '0;
                    rd_ptr_d      = wr_ptr_q;
                    mispredict_d  = 1'b1;
                    redirect_pc_d = bus.res_target;
                    if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
                end
            end else begin
                if (bus.res_valid) err_unf_d = 1'b1;
                if (bus.pred_valid) begin
                    if (full) begin
                        err_ovf_d = 1'b1;
                    end else begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        count_d  = count_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            mispredict_q  <= 1'b0;
            redirect_pc_q <= '0;
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
            err_ovf_q     <= 1'b0;
            err_unf_q     <= 1'b0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            mispredict_q  <= mispredict_d;
            redirect_pc_q <= redirect_pc_d;
            hit_cnt_q     <= hit_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
            err_ovf_q     <= err_ovf_d;
            err_unf_q     <= err_unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_ptr_q] <= bus.pred_ra;
    end

    assign bus.full        = full;
    assign bus.count       = count_q;
    // A pulse pending across a stall is held and shown on the first unstalled cycle.
    assign bus.mispredict  = mispredict_q & ~stall;
    assign bus.redirect_pc = redirect_pc_q;
    assign hit_cnt         = hit_cnt_q;
    assign miss_cnt        = miss_cnt_q;
    assign err_ovf         = err_ovf_q;
    assign err_unf         = err_unf_q;
endmodule

// File: tb/tb_ra_verify.sv
// Directed vector table plus hand sequences for reset and counter saturation.
module tb_ra_verify;
    localparam int PC_W  = 14;
    localparam int DEPTH = 8;
    localparam int CNT_W = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall = 1'b0;
    logic flush_in = 1'b0;
    logic [CNT_W-1:0] hit_cnt, miss_cnt;
    logic err_ovf, err_unf;

    ra_verify_if #(.PC_W(PC_W), .DEPTH(DEPTH)) bus ();

    ra_verify #(.PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush_in(flush_in),
        .bus(bus), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
        .err_ovf(err_ovf), .err_unf(err_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st, fl, pv, rv;
        int unsigned pra, rt;
        int unsigned cnt, hit, miss, redir;
        logic        mp, ovf, unf;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;
    int unsigned cur_redir = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic st, fl, pv, input int unsigned pra, input logic rv,
                       input int unsigned rt, cnt, input logic mp, input int unsigned hit,
                       miss, input logic ovf, unf);
        vec_t v;
        if (mp) cur_redir = rt;
        v.st = st; v.fl = fl; v.pv = pv; v.pra = pra; v.rv = rv; v.rt = rt;
        v.cnt = cnt; v.mp = mp; v.hit = hit; v.miss = miss; v.ovf = ovf; v.unf = unf;
        v.redir = cur_redir;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic st, fl, pv, input int unsigned pra, input logic rv,
                         input int unsigned rt);
        @(negedge clk);
        stall = st; flush_in = fl;
        bus.pred_valid = pv; bus.pred_ra = PC_W'(pra);
        bus.res_valid = rv;  bus.res_target = PC_W'(rt);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 1'b0; flush_in = 1'b0;
        bus.pred_valid = 1'b0; bus.pred_ra = '0;
        bus.res_valid = 1'b0;  bus.res_target = '0;
    endtask

    initial begin
        int unsigned h, m;
        logic o, u;
        idle_inputs();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", bus.count, 0);
        chk("rst_full", bus.full, 0);
        chk("rst_mispredict", bus.mispredict, 0);
        chk("rst_redirect", bus.redirect_pc, 0);
        chk("rst_hit", hit_cnt, 0);
        chk("rst_miss", miss_cnt, 0);
        chk("rst_ovf", err_ovf, 0);
        chk("rst_unf", err_unf, 0);
        @(negedge clk) rst_n = 1'b1;

        // Async reset mid-stream with three entries in flight
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 16'h0040 + i, 0, 0);
        chk("pre_rst_count", bus.count, 3);
        @(negedge clk);
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_count", bus.count, 0);
        chk("async_rst_full", bus.full, 0);
        @(negedge clk) rst_n = 1'b1;
        drive(0, 0, 1, 16'h0077, 0, 0);
        chk("post_rst_push_count", bus.count, 1);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        cur_redir = 0;

        // Vector table: st fl pv pra rv rt | cnt mp hit miss ovf unf
        add(0,0,1,16'h100,0,0,      1,0,0,0,0,0);
        add(0,0,1,16'h200,0,0,      2,0,0,0,0,0);
        add(0,0,1,16'h300,0,0,      3,0,0,0,0,0);
        add(0,0,0,0,1,16'h100,      2,0,1,0,0,0);
        add(0,0,0,0,1,16'h200,      1,0,2,0,0,0);
        add(0,0,0,0,1,16'h300,      0,0,3,0,0,0);
        // Mismatch squash
        add(0,0,1,16'h100,0,0,      1,0,3,0,0,0);
        add(0,0,1,16'h200,0,0,      2,0,3,0,0,0);
        add(0,0,1,16'h300,0,0,      3,0,3,0,0,0);
        add(0,0,0,0,1,16'h100,      2,0,4,0,0,0);
        add(0,0,1,16'h222,1,16'hAAA,0,1,4,1,0,0);
        add(0,0,0,0,0,0,            0,0,4,1,0,0);
        // Fill, overflow, push+pop while full, then drain in order
        for (int i = 0; i < DEPTH; i++) add(0,0,1,16'h10 + i,0,0, i + 1,0,4,1,0,0);
        add(0,0,1,16'h3FF,0,0,      8,0,4,1,1,0);
        add(0,0,1,16'h111,1,16'h10, 8,0,5,1,1,0);
        for (int i = 1; i < DEPTH; i++) add(0,0,0,0,1,16'h10 + i, DEPTH - i,0,5 + i,1,1,0);
        add(0,0,0,0,1,16'h111,      0,0,13,1,1,0);
        // Stall freezes, flush wins over a mismatching resolve
        add(0,0,1,16'h050,0,0,      1,0,13,1,1,0);
        add(0,0,1,16'h060,0,0,      2,0,13,1,1,0);
        add(1,0,1,16'h061,1,16'h007,2,0,13,1,1,0);
        add(0,1,1,16'h062,1,16'h007,0,0,13,1,1,0);
        add(0,0,1,16'h070,0,0,      1,0,13,1,1,0);
        add(0,0,0,0,1,16'h070,      0,0,14,1,1,0);
        // Underflow, and a push alongside an empty resolve
        add(0,0,0,0,1,16'h123,      0,0,14,1,1,1);
        add(0,0,1,16'h200,1,16'h321,1,0,14,1,1,1);
        add(0,0,0,0,1,16'h200,      0,0,15,1,1,1);

        foreach (vecs[k]) begin
            vec_t v;
            v = vecs[k];
            drive(v.st, v.fl, v.pv, v.pra, v.rv, v.rt);
            chk($sformatf("v%0d_count", k), bus.count, v.cnt);
            chk($sformatf("v%0d_full", k), bus.full, (v.cnt == DEPTH) ? 1 : 0);
            chk($sformatf("v%0d_mispredict", k), bus.mispredict, v.mp);
            chk($sformatf("v%0d_redirect", k), bus.redirect_pc, v.redir);
            chk($sformatf("v%0d_hit", k), hit_cnt, v.hit);
            chk($sformatf("v%0d_miss", k), miss_cnt, v.miss);
            chk($sformatf("v%0d_ovf", k), err_ovf, v.ovf);
            chk($sformatf("v%0d_unf", k), err_unf, v.unf);
        end

        // Saturation: one entry in flight, push+matching resolve each cycle
        h = vecs[vecs.size()-1].hit;
        m = vecs[vecs.size()-1].miss;
        o = vecs[vecs.size()-1].ovf;
        u = vecs[vecs.size()-1].unf;
        drive(0, 0, 1, 16'h005, 0, 0);
        for (int i = 0; i < 65535 - int'(h); i++) drive(0, 0, 1, 16'h005, 1, 16'h005);
        chk("sat_reach_hit", hit_cnt, 16'hFFFF);
        chk("sat_reach_count", bus.count, 1);
        drive(0, 0, 1, 16'h005, 1, 16'h005);
        chk("sat_hold_hit", hit_cnt, 16'hFFFF);
        chk("sat_hold_count", bus.count, 1);
        chk("sat_miss", miss_cnt, m);
        chk("sat_ovf", err_ovf, o);
        chk("sat_unf", err_unf, u);
        chk("sat_mispredict", bus.mispredict, 0);

        @(negedge clk);
        idle_inputs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
